// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execution ALU: ALUsel codes (also used by the
// ALU control decoder), FSM state encoding and the default datapath width.
package alu_exec_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_iter_datapath.sv
// Iterative accumulator for the multi-cycle ops: 1-bit-per-cycle shifts and
// a shift-add multiplier. Steps every cycle while its down-counter is non-zero.
module alu_iter_datapath
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] acc_nxt_o,
    output logic            last_o
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = SHW + 1;

    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            op_d = op_i;
            if (op_i == ALU_MUL) begin
                acc_d    = '0;
                mcand_d  = a_i;
                mplier_d = b_i;
                cnt_d    = CNTW'(XLEN);
            end else begin
                acc_d = a_i;
                cnt_d = CNTW'(b_i[SHW-1:0]);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
            case (op_q)
                ALU_SLL: acc_d = acc_q << 1;
                ALU_SRL: acc_d = acc_q >> 1;
                ALU_SRA: acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
                ALU_MUL: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= ALU_AND;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // The step that consumes the final count produces the finished value.
    assign acc_nxt_o = acc_d;
    assign last_o    = (cnt_q == CNTW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execution ALU: single-cycle logic/arith in this module,
// shifts and MUL delegated to alu_iter_datapath.
//   state    | meaning
//   ST_IDLE  | in_ready=1, waiting for an op
//   ST_SHIFT | iterative shift running, one bit per cycle
//   ST_MUL   | 32-step shift-add multiply running
//   ST_DONE  | out_valid=1, holding result until out_ready
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUsel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q;
    logic            in_ready_q, out_valid_q, zero_q, illegal_q;
    logic [XLEN-1:0] result_q;

    logic            accept, legal, is_shift, is_mul, iter_load, iter_last;
    logic [XLEN-1:0] single_res, iter_res;
    logic [SHW-1:0]  shamt;

    assign accept = in_valid & in_ready_q;
    assign shamt  = b[SHW-1:0];

    always_comb begin
        single_res = '0;
        legal      = 1'b1;
        is_shift   = 1'b0;
        is_mul     = 1'b0;
        case (ALUsel)
            ALU_AND: single_res = a & b;
            ALU_OR:  single_res = a | b;
            ALU_ADD: single_res = a + b;
            ALU_SUB: single_res = a - b;
            ALU_XOR: single_res = a ^ b;
            ALU_SLT: single_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                is_shift   = 1'b1;
                single_res = a;
            end
            ALU_MUL: begin
                is_mul = MUL_ENABLE;
                legal  = MUL_ENABLE;
            end
            default: legal = 1'b0;
        endcase
    end

    assign iter_load = accept & (is_mul | (is_shift & (shamt != '0)));

    alu_iter_datapath #(.XLEN(XLEN)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (iter_load),
        .op_i      (ALUsel),
        .a_i       (a),
        .b_i       (b),
        .acc_nxt_o (iter_res),
        .last_o    (iter_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (is_mul) begin
                            state_q <= ST_MUL;
                        end else if (is_shift && shamt != '0) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= legal ? single_res : '0;
                            zero_q      <= legal ? (single_res == '0) : 1'b1;
                            illegal_q   <= ~legal;
                        end
                    end
                end
                ST_SHIFT, ST_MUL: begin
                    if (iter_last) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= iter_res;
                        zero_q      <= (iter_res == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
